// File: rtl/halfadder_serial_seq.sv
// Bit-serial WIDTH-bit adder with carry-in. A single NAND-built half adder is
// time-shared: every bit takes two passes (operands, then running carry).
// Start/busy/done handshake toward the requester.

// Half adder built only from 2-input NAND gates.
module halfadder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  logic n_ab, n_a, n_b;

  assign n_ab  = ~(a & b);
  assign n_a   = ~(a & n_ab);
  assign n_b   = ~(b & n_ab);
  assign sum   = ~(n_a & n_b);
  assign carry = ~(n_ab & n_ab);
endmodule

module halfadder_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS1 = 2'd1,
    S_PASS2 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             c_q, c_d;     // running carry between bits
  logic             p_q, p_d;     // propagate bit from pass 1
  logic             g1_q, g1_d;   // generate carry from pass 1
  logic             cout_q, cout_d;

  logic ha_a, ha_b, ha_sum, ha_carry;

  // Shared half adder fed from registered state only: operand bits in pass 1,
  // propagate bit and running carry in pass 2.
  always_comb begin
    ha_a = p_q;
    ha_b = c_q;
    if (state_q == S_PASS1) begin
      ha_a = a_q[idx_q];
      ha_b = b_q[idx_q];
    end
  end

  halfadder u_ha (
    .a     (ha_a),
    .b     (ha_b),
    .sum   (ha_sum),
    .carry (ha_carry)
  );

  // Next-state and datapath updates for the two-pass-per-bit sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    c_d     = c_q;
    p_d     = p_q;
    g1_d    = g1_q;
    cout_d  = cout_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          c_d     = cin;
          idx_d   = '0;
          state_d = S_PASS1;
        end
      end
      S_PASS1: begin
        p_d     = ha_sum;
        g1_d    = ha_carry;
        state_d = S_PASS2;
      end
      S_PASS2: begin
        acc_d[idx_q] = ha_sum;
        // g1 and the pass-2 carry are mutually exclusive, so OR is exact.
        c_d = g1_q | ha_carry;
        if (idx_q == LAST) begin
          sum_d   = acc_d;
          cout_d  = c_d;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_PASS1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      p_q     <= 1'b0;
      g1_q    <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      p_q     <= p_d;
      g1_q    <= g1_d;
      cout_q  <= cout_d;
    end
  end

  assign busy    = (state_q == S_PASS1) || (state_q == S_PASS2);
  assign done    = (state_q == S_DONE);
  assign sum_out = sum_q;
  assign cout    = cout_q;
endmodule

// File: tb/tb_halfadder_serial_seq.sv
// Self-checking bench: directed handshake cases plus randomized operands,
// each compared against plain integer addition.
module tb_halfadder_serial_seq;
  localparam int W   = 8;
  localparam int LAT = 2 * W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum_out;
  logic         cout;

  int n_cmp = 0;
  int n_err = 0;
  logic [W:0] prev_res;

  halfadder_serial_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    int s;
    s = int'(a) + int'(b) + int'(c);
    return s[W:0];
  endfunction

  // One add: accept at the next edge, optional ignored re-start at cycle
  // restart_at, then check latency, busy, held result, value and done width.
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input int restart_at);
    int   cyc;
    logic held_ok, busy_ok;
    logic [W:0] exp;
    exp = ref_add(a, b, c);
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b; cin = c;
    @(negedge clk);                       // between E0 and E0+1
    start = 1'b0;
    cyc = 0; held_ok = 1'b1; busy_ok = 1'b1;
    while (!done && cyc < LAT + 20) begin
      if (!busy) busy_ok = 1'b0;
      if ({cout, sum_out} !== prev_res) held_ok = 1'b0;
      if (cyc == restart_at) begin
        start = 1'b1; a_in = 8'd100; b_in = 8'd100; cin = 1'b1;
      end else begin
        start = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", cyc, LAT);
    chk("busy_during_op", busy_ok, 1);
    chk("result_held", held_ok, 1);
    chk("result", {cout, sum_out}, exp);
    chk("busy_at_done", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    if (restart_at >= 0) begin
      repeat (3) @(negedge clk);
      chk("restart_ignored_busy", busy, 0);
      chk("restart_ignored_done", done, 0);
    end
    prev_res = exp;
  endtask

  initial begin
    int cyc, dones;
    logic [W-1:0] vals [5];
    vals[0] = 8'd0; vals[1] = 8'd1; vals[2] = 8'd127; vals[3] = 8'd128; vals[4] = 8'd255;

    rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum_out, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;
    prev_res = '0;

    // Directed cases
    run_add(8'd3,   8'd5,   1'b0, -1);
    run_add(8'd255, 8'd1,   1'b0, -1);
    run_add(8'd255, 8'd255, 1'b1, -1);
    run_add(8'd0,   8'd0,   1'b1, -1);
    run_add(8'd10,  8'd20,  1'b0, 5);

    // Reset in the middle of an add: no done, outputs cleared
    @(negedge clk);
    start = 1'b1; a_in = 8'd77; b_in = 8'd88; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_sum", sum_out, 0);
    chk("midrst_cout", cout, 0);
    dones = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midrst_no_done", dones, 0);
    prev_res = '0;
    run_add(8'd200, 8'd57, 1'b1, -1);

    // start held high: back-to-back accepts every 2*W+2 cycles
    @(negedge clk);
    start = 1'b1; a_in = 8'd1; b_in = 8'd1; cin = 1'b0;
    @(negedge clk);                       // after E0
    a_in = 8'd2; b_in = 8'd2;
    cyc = 0;
    while (!done && cyc < LAT + 20) begin @(negedge clk); cyc++; end
    chk("held_first_latency", cyc, LAT);
    chk("held_first_result", {cout, sum_out}, 2);
    @(negedge clk); cyc++;
    chk("held_gap_busy", busy, 0);
    @(negedge clk); cyc++;
    chk("held_second_accept", busy, 1);
    while (!done && cyc < 2 * LAT + 30) begin @(negedge clk); cyc++; end
    start = 1'b0;
    chk("held_second_latency", cyc, 2 * LAT + 2);
    chk("held_second_result", {cout, sum_out}, 4);
    prev_res = 9'd4;
    repeat (3) @(negedge clk);

    // Corner-value grid
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        for (int k = 0; k < 2; k++)
          run_add(vals[i], vals[j], k[0], -1);

    // Random operands
    for (int n = 0; n < 1000; n++)
      run_add(W'($urandom), W'($urandom), 1'($urandom), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
